// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams FIR tap coefficients into a shadow bank and swaps
// the full set into the active bank at a datapath safe point.
module fir_coeff_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS = 8,
    localparam int IDX_WIDTH = $clog2(NUM_TAPS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [DATA_WIDTH-1:0]          coeff_in,
    input  logic                           coeff_valid,
    output logic                           coeff_ready,
    input  logic                           swap_ok,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] h_out,
    output logic                           busy,
    output logic                           coeff_updated,
    output logic                           load_error
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;
    state_t state, state_nxt;
    logic [IDX_WIDTH-1:0] idx;
    logic [NUM_TAPS*DATA_WIDTH-1:0] shadow;
    logic accept, last, swap, err, restart;
    assign last = idx == IDX_WIDTH'(NUM_TAPS - 1);
    always_comb begin
        state_nxt = state;
        accept = 1'b0;
        swap = 1'b0;
        err = 1'b0;
        restart = 1'b0;
        case (state)
            IDLE: begin
                restart = start;
                state_nxt = start ? LOAD : IDLE;
            end
            LOAD: begin
                err = start;
                restart = start;
                accept = !start && coeff_valid && coeff_ready;
                state_nxt = (accept && last) ? WAIT_SWAP : LOAD;
            end
            WAIT_SWAP: begin
                err = start;
                swap = swap_ok;
                state_nxt = swap_ok ? IDLE : WAIT_SWAP;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            shadow <= '0;
            h_out <= '0;
            coeff_ready <= 1'b0;
            busy <= 1'b0;
            coeff_updated <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state <= state_nxt;
            coeff_ready <= state_nxt == LOAD;
            busy <= state_nxt != IDLE;
            coeff_updated <= swap;
            load_error <= err;
            // the last beat parks idx at 0 so it never exceeds NUM_TAPS-1
            if (restart || (accept && last))
                idx <= '0;
            else if (accept)
                idx <= idx + 1'b1;
            if (accept)
                shadow[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= coeff_in;
            if (swap)
                h_out <= shadow;
        end
    end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed checks of load, restart, wait/swap and reset behaviour.
module tb_fir_coeff_loader;
    logic clk = 1'b0;
    logic reset, start, coeff_valid, coeff_ready, swap_ok, busy, coeff_updated, load_error;
    logic [15:0] coeff_in;
    logic [63:0] h_out;
    int total = 0;
    int bad = 0;

    fir_coeff_loader #(.DATA_WIDTH(16), .NUM_TAPS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .coeff_in(coeff_in),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .swap_ok(swap_ok),
        .h_out(h_out), .busy(busy), .coeff_updated(coeff_updated), .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic r, input logic b, input logic u, input logic e);
        chk({tag, "_ready"}, coeff_ready, r);
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_upd"}, coeff_updated, u);
        chk({tag, "_err"}, load_error, e);
    endtask

    task automatic begin_load();
        start = 1'b1;
        step();
        start = 1'b0;
        chk_flags("start", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic beat(input logic [15:0] v);
        coeff_valid = 1'b1;
        coeff_in = v;
        step();
        coeff_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        coeff_valid = 1'b0;
        coeff_in = 16'h0;
        swap_ok = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset_h", h_out, 64'h0);
        chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        // valid beats in IDLE must be ignored
        coeff_valid = 1'b1;
        coeff_in = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_h", h_out, 64'h0);
            chk_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        coeff_valid = 1'b0;

        // back-to-back beats, swap_ok already high
        swap_ok = 1'b1;
        begin_load();
        beat(16'h0100);
        beat(16'hFF00);
        beat(16'h7FFF);
        chk("b2b_mid_ready", coeff_ready, 1'b1);
        beat(16'h8000);
        chk("b2b_wait_h", h_out, 64'h0);
        chk_flags("b2b_wait", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("b2b_swap_h", h_out, 64'h8000_7FFF_FF00_0100);
        chk_flags("b2b_swap", 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("b2b_after_h", h_out, 64'h8000_7FFF_FF00_0100);
        chk_flags("b2b_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // gapped beats, swap held off for 10 cycles
        reset = 1'b1;
        swap_ok = 1'b0;
        step();
        reset = 1'b0;
        chk("rst2_h", h_out, 64'h0);
        begin_load();
        step();
        chk("gap_ready", coeff_ready, 1'b1);
        beat(16'h0100);
        step();
        beat(16'hFF00);
        step();
        beat(16'h7FFF);
        step();
        chk("gap_ready2", coeff_ready, 1'b1);
        beat(16'h8000);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_h", h_out, 64'h0);
            chk_flags("hold", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        swap_ok = 1'b1;
        step();
        swap_ok = 1'b0;
        chk("gap_swap_h", h_out, 64'h8000_7FFF_FF00_0100);
        chk_flags("gap_swap", 1'b0, 1'b0, 1'b1, 1'b0);

        // restart mid-load; the beat coinciding with start is discarded
        begin_load();
        beat(16'h1111);
        beat(16'h2222);
        start = 1'b1;
        beat(16'h3333);
        start = 1'b0;
        chk_flags("restart", 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("restart_err_clr", load_error, 1'b0);
        beat(16'h000A);
        beat(16'h000B);
        beat(16'h000C);
        beat(16'h000D);
        chk("restart_wait_h", h_out, 64'h8000_7FFF_FF00_0100);
        swap_ok = 1'b1;
        step();
        swap_ok = 1'b0;
        chk("restart_swap_h", h_out, 64'h000D_000C_000B_000A);
        chk_flags("restart_swap", 1'b0, 1'b0, 1'b1, 1'b0);

        // start while waiting, then swap
        begin_load();
        beat(16'h0001);
        beat(16'h0002);
        beat(16'h0003);
        beat(16'h0004);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("wstart_h", h_out, 64'h000D_000C_000B_000A);
        chk_flags("wstart", 1'b0, 1'b1, 1'b0, 1'b1);
        swap_ok = 1'b1;
        step();
        swap_ok = 1'b0;
        chk("wstart_swap_h", h_out, 64'h0004_0003_0002_0001);
        chk_flags("wstart_swap", 1'b0, 1'b0, 1'b1, 1'b0);

        // start and swap_ok together in WAIT_SWAP
        begin_load();
        beat(16'h0005);
        beat(16'h0006);
        beat(16'h0007);
        beat(16'h0008);
        start = 1'b1;
        swap_ok = 1'b1;
        step();
        start = 1'b0;
        swap_ok = 1'b0;
        chk("both_h", h_out, 64'h0008_0007_0006_0005);
        chk_flags("both", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_flags("both_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-load clears the active bank
        swap_ok = 1'b1;
        begin_load();
        for (int i = 0; i < 4; i++) beat(16'h0001);
        step();
        chk("ones_h", h_out, 64'h0001_0001_0001_0001);
        swap_ok = 1'b0;
        begin_load();
        beat(16'h0009);
        beat(16'h0009);
        beat(16'h0009);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_h", h_out, 64'h0);
        chk_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        swap_ok = 1'b1;
        begin_load();
        beat(16'h0010);
        beat(16'h0020);
        beat(16'h0030);
        beat(16'h0040);
        step();
        chk("final_h", h_out, 64'h0040_0030_0020_0010);
        chk_flags("final", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Writer side of the FIR tap coefficient interface. Accepts tap coefficients as a serial valid/ready stream and assembles them in a shadow bank. Once the datapath signals a safe point, it swaps the full set into an active bank in a single edge. The active bank drives the h_in inputs of the systolic FIR tap chain, so taps never see a partially updated coefficient set.

Parameters:
DATA_WIDTH, 16, coefficient width (signed Q-format, same as tap h_in)
NUM_TAPS, 8, number of taps / coefficients per set (>=2)
IDX_WIDTH, $clog2(NUM_TAPS), tap index counter width (derived; do not override)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin loading a new coefficient set
coeff_in  in  DATA_WIDTH  signed coefficient beat; first beat is h[0]
coeff_valid  in  1  coeff_in valid
coeff_ready  out  1  loader accepts a beat this cycle
swap_ok  in  1  datapath safe point (sample boundary / enable low); permits swap
h_out  out  NUM_TAPS*DATA_WIDTH  active coefficients; h[i] at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
busy  out  1  high whenever state != IDLE
coeff_updated  out  1  one-cycle pulse on the cycle after the active bank changes
load_error  out  1  one-cycle pulse when start is illegal or restarts a load

Behaviour:
- Reset: state=IDLE; idx=0; shadow and active banks all zero (h_out=0); coeff_ready=0, busy=0, coeff_updated=0, load_error=0. Reset mid-load or mid-wait abandons the set and also clears the active bank.
- All outputs are registered. coeff_ready is a function of state only (high only in LOAD). It does not depend combinationally on coeff_valid.
- IDLE: start=1 -> LOAD, idx<=0. coeff_ready rises the next cycle. coeff_valid is ignored in IDLE.
- LOAD: a beat is accepted when coeff_valid & coeff_ready. On accept: shadow[idx]<=coeff_in, idx<=idx+1. The accept with idx==NUM_TAPS-1 -> WAIT_SWAP and coeff_ready=0 next cycle. Gaps (valid low) are allowed indefinitely.
- start in LOAD: load restarts. idx<=0, stay in LOAD, load_error pulses. If a beat is accepted on the same cycle, it is discarded. Earlier shadow entries are retained but are overwritten by the new sequence.
- WAIT_SWAP: coeff_ready=0. When swap_ok=1, all NUM_TAPS active registers <= shadow on the same edge -> IDLE.
  - New h_out is visible the cycle after swap_ok is sampled.
  - coeff_updated pulses high on that same cycle.
  - If swap_ok is already high on WAIT_SWAP entry, the swap happens on the first WAIT_SWAP cycle (minimum 1 cycle between the last beat and the swap edge).
- start in WAIT_SWAP: ignored for state, load_error pulses. The pending set still swaps.
- start and swap_ok in the same WAIT_SWAP cycle: the swap happens, load_error pulses, and the FSM returns to IDLE (no new load).
- h_out changes only at a swap edge or at reset. It never shows a mix of old and new sets.
- No arithmetic: coefficients are stored bit-exact (signed, no saturation or rounding).
- idx never exceeds NUM_TAPS-1. There is no wrap in LOAD because the FSM leaves LOAD on the last beat.

Test Plan (NUM_TAPS=4, DATA_WIDTH=16):
- Reset, then idle 5 cycles -> h_out=0, coeff_ready=0, busy=0, no pulses.
- start, stream 0x0100,0xFF00,0x7FFF,0x8000 back-to-back with swap_ok=1 -> swap one cycle after the last beat; h_out=0x8000_7FFF_FF00_0100; coeff_updated is a 1-cycle pulse; busy falls with it.
- Same set with coeff_valid toggling every other cycle and swap_ok held 0 for 10 cycles after the last beat -> h_out stays old (0) until swap_ok rises, then updates the next cycle.
- start, 2 beats (0x1111,0x2222), start again, 4 beats 0xA,0xB,0xC,0xD -> load_error pulses once; after swap h_out=0x000D_000C_000B_000A.
- In WAIT_SWAP, assert start with swap_ok=0, then swap_ok=1 -> load_error pulse; pending set swaps; FSM ends in IDLE; coeff_ready stays 0.
- Reset asserted after 3 of 4 beats while a prior set (0x0001 x4) is active -> h_out=0, state IDLE. A subsequent full load swaps normally.
